serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built on one full_adder cell plus a carry flip-flop.

---
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built on a single full_adder cell

// Single-bit full adder cell shared with the rest of the adder library
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of three single-bit inputs
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule

// Adds a + b + ci LSB first, one bit per clock, and reports the result in parallel
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // A one-bit counter is still needed for WIDTH=1 so the compare stays well formed
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic             fa_s;
  logic             fa_co;

  // The one adder cell always looks at the current LSBs and the running carry
  full_adder u_fa (
    .a_i  (sha_q[0]),
    .b_i  (shb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Next-state and datapath updates; start is honoured only in IDLE and DONE
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          co_d    = fa_co;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts a computation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  // Status strobes decode directly from the state register
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    co   = co_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 8, 4 and 1

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       start8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start4, ci4, busy4, done4, co4;
  logic [3:0] a4, b4, sum4;
  logic       start1, ci1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];
  logic [1:0] sb1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .co(co4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until done8; cyc counts cycles since the call, bc counts busy cycles seen
  task automatic wait_done8(input string tag, output int cyc, output int bc);
    bit seen;
    seen = 0;
    cyc  = 0;
    bc   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cyc = i;
      if (busy8) bc++;
      if (done8) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  // One WIDTH=8 transaction; a second start with a=55 is pulsed at cycle inj (0 = none)
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input int inj);
    int cyc, bc;
    bit seen;
    logic [8:0] exp;
    sb8.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    seen = 0; cyc = 0; bc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cyc = i;
      start8 = (i == inj);
      if (i == inj) a8 = 8'h55;
      if (busy8) bc++;
      if (done8) begin
        seen = 1;
        break;
      end
    end
    start8 = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, bc, 8);
    exp = sb8.pop_front();
    check({tag, "_result"}, {co8, sum8}, exp);
    tick();
    check({tag, "_single_done"}, {busy8, done8}, 2'b00);
  endtask

  initial begin
    int cyc, bc, dcount;
    logic [8:0] e8;
    logic [4:0] e4;
    logic [1:0] e1;

    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    start4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    start1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    tick(); tick(); tick();

    // reset state
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 8'h00);
    check("rst_co", co8, 0);
    rst = 1'b0;
    tick();

    // basic additions
    run8("t1_0f_01", 8'h0F, 8'h01, 1'b0, 0);
    run8("t2_ff_01", 8'hFF, 8'h01, 1'b0, 0);
    run8("t2_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0);

    // start re-pulsed during RUN is ignored
    run8("t3_ignore", 8'h12, 8'h34, 1'b0, 3);
    tick(); tick();
    check("t3_idle_after", {busy8, done8}, 2'b00);
    check("t3_sum_hold", sum8, 8'h46);

    // reset in the middle of RUN
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; start8 = 1'b1;
    tick(); start8 = 1'b0;
    tick(); tick(); tick();
    check("t4_busy_before_rst", busy8, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", busy8, 0);
    check("t4_done", done8, 0);
    check("t4_sum", sum8, 8'h00);
    check("t4_co", co8, 0);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8 || busy8) dcount++;
    end
    check("t4_no_done_after_rst", dcount, 0);
    run8("t4_fresh", 8'h3C, 8'hC3, 1'b1, 0);

    // back-to-back: start held in the DONE cycle
    sb8.push_back(9'h033);
    a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; start8 = 1'b1;
    tick(); start8 = 1'b0;
    for (int i = 2; i <= 8; i++) tick();
    check("t5_busy_c8", busy8, 1);
    sb8.push_back(9'h100);
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; start8 = 1'b1;
    tick();
    check("t5_done_c9", done8, 1);
    e8 = sb8.pop_front();
    check("t5_first_result", {co8, sum8}, e8);
    tick();
    start8 = 1'b0;
    check("t5_rerun_busy", busy8, 1);
    wait_done8("t5_second", cyc, bc);
    check("t5_second_latency", cyc + 1, 9);
    check("t5_second_busy", bc + 1, 8);
    e8 = sb8.pop_front();
    check("t5_second_result", {co8, sum8}, e8);
    tick();

    // WIDTH=4 exhaustive
    for (int v = 0; v < 512; v++) begin
      a4 = v[3:0]; b4 = v[7:4]; ci4 = v[8];
      sb4.push_back({1'b0, a4} + {1'b0, b4} + {4'd0, ci4});
      start4 = 1'b1;
      tick(); start4 = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (done4) begin
          cyc = i + 1;
          break;
        end
      end
      e4 = sb4.pop_front();
      if (v == 0 || v == 511) check("w4_latency", cyc, 5);
      check($sformatf("w4_a%0h_b%0h_c%0d", v[3:0], v[7:4], v[8]), {co4, sum4}, e4);
    end

    // WIDTH=1 truth table
    for (int v = 0; v < 8; v++) begin
      a1 = v[0]; b1 = v[1]; ci1 = v[2];
      sb1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, ci1});
      start1 = 1'b1;
      tick(); start1 = 1'b0;
      check("w1_busy_c1", busy1, 1);
      cyc = 0;
      for (int i = 1; i <= 10; i++) begin
        if (done1) begin
          cyc = i;
          break;
        end
        tick();
      end
      check("w1_done_cycle", cyc, 2);
      e1 = sb1.pop_front();
      check($sformatf("w1_%0d%0d%0d", v[0], v[1], v[2]), {co1, sum1}, e1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
